// File: rtl/fp_chk_pkg.sv
// Shared FP-format helpers and result type for the lockstep checker.
// Helpers take the format widths as arguments so that one package serves every instance width.
package fp_chk_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MAX_W  = 64;

  typedef logic [FP_MAX_W-1:0] fp_word_t;

  typedef struct packed {
    logic                 mismatch;
    logic [FP_DATA_W-1:0] ref_val;
    logic [FP_DATA_W-1:0] dut_val;
  } cmp_res_t;

  function automatic fp_word_t fp_man_mask(input int unsigned dw, input int unsigned ew);
    return {FP_MAX_W{1'b1}} >> (FP_MAX_W - (dw - 32'd1 - ew));
  endfunction

  function automatic fp_word_t fp_exp_mask(input int unsigned dw, input int unsigned ew);
    return ({FP_MAX_W{1'b1}} >> (FP_MAX_W - ew)) << (dw - 32'd1 - ew);
  endfunction

  function automatic logic fp_is_nan(input fp_word_t x, input int unsigned dw, input int unsigned ew);
    return ((x & fp_exp_mask(dw, ew)) == fp_exp_mask(dw, ew)) && ((x & fp_man_mask(dw, ew)) != '0);
  endfunction

  function automatic logic fp_is_zero(input fp_word_t x, input int unsigned dw, input int unsigned ew);
    return (x & (fp_exp_mask(dw, ew) | fp_man_mask(dw, ew))) == '0;
  endfunction

  // Monotonic integer image of a float: negatives inverted, positives get the sign bit set.
  function automatic fp_word_t fp_to_ord(input fp_word_t x, input int unsigned dw);
    fp_word_t sign_mask;
    fp_word_t val_mask;
    sign_mask = 64'd1 << (dw - 32'd1);
    val_mask  = {FP_MAX_W{1'b1}} >> (FP_MAX_W - dw);
    if ((x & sign_mask) != '0) begin
      return ~x & val_mask;
    end else begin
      return (x | sign_mask) & val_mask;
    end
  endfunction

endpackage

// File: rtl/fp_ulp_cmp.sv
// Combinational per-channel comparator: NaN and signed-zero aware, with an ULP window.
module fp_ulp_cmp
  import fp_chk_pkg::*;
#(
  parameter int DATA_W  = FP_DATA_W,
  parameter int EXP_W   = FP_EXP_W,
  parameter int ULP_TOL = 0,
  parameter int ZERO_EQ = 1
) (
  input  logic [DATA_W-1:0] ref_val,
  input  logic [DATA_W-1:0] dut_val,
  output logic              mismatch
);

  localparam logic [DATA_W:0] TOL = (DATA_W+1)'(ULP_TOL);

  fp_word_t          ref_ext_s;
  fp_word_t          dut_ext_s;
  logic              ref_nan_s;
  logic              dut_nan_s;
  logic              ref_zero_s;
  logic              dut_zero_s;
  logic [DATA_W-1:0] ref_ord_s;
  logic [DATA_W-1:0] dut_ord_s;
  logic [DATA_W:0]   diff_s;
  logic [DATA_W:0]   abs_s;

  assign ref_ext_s  = fp_word_t'(ref_val);
  assign dut_ext_s  = fp_word_t'(dut_val);
  assign ref_nan_s  = fp_is_nan(ref_ext_s, DATA_W, EXP_W);
  assign dut_nan_s  = fp_is_nan(dut_ext_s, DATA_W, EXP_W);
  assign ref_zero_s = fp_is_zero(ref_ext_s, DATA_W, EXP_W);
  assign dut_zero_s = fp_is_zero(dut_ext_s, DATA_W, EXP_W);
  assign ref_ord_s  = DATA_W'(fp_to_ord(ref_ext_s, DATA_W));
  assign dut_ord_s  = DATA_W'(fp_to_ord(dut_ext_s, DATA_W));

  // Match decision: NaN class first, then zero equivalence, then ordered distance.
  always_comb begin
    mismatch = 1'b0;
    diff_s   = {1'b0, ref_ord_s} - {1'b0, dut_ord_s};
    if (diff_s[DATA_W]) begin
      abs_s = ~diff_s + (DATA_W+1)'(1'b1);
    end else begin
      abs_s = diff_s;
    end
    if (ref_nan_s && dut_nan_s) begin
      mismatch = 1'b0;
    end else if (ref_nan_s || dut_nan_s) begin
      mismatch = 1'b1;
    end else if ((ZERO_EQ != 32'sd0) && ref_zero_s && dut_zero_s) begin
      mismatch = 1'b0;
    end else begin
      mismatch = (abs_s > TOL);
    end
  end

endmodule

// File: rtl/fp_lockstep_checker.sv
// Lockstep checker: realigns a single-cycle reference unit against a pipelined unit,
// compares every channel and keeps sticky flags, saturating counters and a first-error snapshot.
module fp_lockstep_checker
  import fp_chk_pkg::*;
#(
  parameter  int DATA_W  = FP_DATA_W,
  parameter  int EXP_W   = FP_EXP_W,
  parameter  int N_CH    = 2,
  parameter  int LAT_REF = 1,
  parameter  int LAT_DUT = 4,
  parameter  int ULP_TOL = 0,
  parameter  int ZERO_EQ = 1,
  parameter  int CNT_W   = 16,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [N_CH*DATA_W-1:0] ref_z,
  input  logic [N_CH*DATA_W-1:0] dut_z,
  output logic                   cmp_valid,
  output logic [N_CH-1:0]        mismatch,
  output logic [N_CH-1:0]        sticky_err,
  output logic [N_CH*CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]       cmp_cnt,
  output logic                   fe_valid,
  output logic [CH_W-1:0]        fe_ch,
  output logic [DATA_W-1:0]      fe_ref,
  output logic [DATA_W-1:0]      fe_dut,
  output logic [CNT_W-1:0]       fe_idx
);

  localparam int D = LAT_DUT - LAT_REF;

  logic [LAT_DUT-1:0]     vld_r;
  logic [N_CH*DATA_W-1:0] ref_al_s;
  logic [N_CH-1:0]        mm_s;
  logic                   fire_s;
  cmp_res_t               first_s;
  logic [CH_W-1:0]        first_ch_s;

  assign fire_s = vld_r[LAT_DUT-1];

  // Valid shift register tracking operands through the dut pipeline
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      vld_r <= '0;
    end else begin
      vld_r[0] <= in_valid;
      for (int i = 1; i < LAT_DUT; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
    end
  end

  if (D == 0) begin : g_nodly
    assign ref_al_s = ref_z;
  end else begin : g_dly
    logic                   tap_s;
    logic [N_CH*DATA_W-1:0] dly_r [D];

    if (LAT_REF == 0) begin : g_tap_in
      assign tap_s = in_valid;
    end else begin : g_tap_pipe
      assign tap_s = vld_r[LAT_REF-1];
    end

    // Reference delay line; non-valid slots are zeroed so stray X never enters
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        for (int i = 0; i < D; i++) begin
          dly_r[i] <= '0;
        end
      end else begin
        dly_r[0] <= tap_s ? ref_z : '0;
        for (int i = 1; i < D; i++) begin
          dly_r[i] <= dly_r[i-1];
        end
      end
    end

    assign ref_al_s = dly_r[D-1];
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    fp_ulp_cmp #(
      .DATA_W  (DATA_W),
      .EXP_W   (EXP_W),
      .ULP_TOL (ULP_TOL),
      .ZERO_EQ (ZERO_EQ)
    ) u_cmp (
      .ref_val  (ref_al_s[c*DATA_W +: DATA_W]),
      .dut_val  (dut_z[c*DATA_W +: DATA_W]),
      .mismatch (mm_s[c])
    );
  end

  // Lowest mismatching channel wins; scanning downward lets lower indices overwrite
  always_comb begin
    first_s          = '0;
    first_ch_s       = '0;
    first_s.mismatch = |mm_s;
    for (int c = N_CH - 1; c >= 0; c--) begin
      first_ch_s      = mm_s[c] ? CH_W'(c) : first_ch_s;
      first_s.ref_val = mm_s[c] ? FP_DATA_W'(ref_al_s[c*DATA_W +: DATA_W]) : first_s.ref_val;
      first_s.dut_val = mm_s[c] ? FP_DATA_W'(dut_z[c*DATA_W +: DATA_W]) : first_s.dut_val;
    end
  end

  // Registered compare result, sticky flags, saturating counters and snapshot
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cmp_valid  <= 1'b0;
      mismatch   <= '0;
      sticky_err <= '0;
      err_cnt    <= '0;
      cmp_cnt    <= '0;
      fe_valid   <= 1'b0;
      fe_ch      <= '0;
      fe_ref     <= '0;
      fe_dut     <= '0;
      fe_idx     <= '0;
    end else begin
      cmp_valid <= fire_s;
      if (fire_s) begin
        mismatch   <= mm_s;
        sticky_err <= sticky_err | mm_s;
        if (cmp_cnt != '1) begin
          cmp_cnt <= cmp_cnt + CNT_W'(1'b1);
        end
        for (int c = 0; c < N_CH; c++) begin
          if (mm_s[c] && (err_cnt[c*CNT_W +: CNT_W] != '1)) begin
            err_cnt[c*CNT_W +: CNT_W] <= err_cnt[c*CNT_W +: CNT_W] + CNT_W'(1'b1);
          end
        end
        // fe_idx takes the pre-increment count, so the first compare is index 0
        if (first_s.mismatch && !fe_valid) begin
          fe_valid <= 1'b1;
          fe_ch    <= first_ch_s;
          fe_ref   <= DATA_W'(first_s.ref_val);
          fe_dut   <= DATA_W'(first_s.dut_val);
          fe_idx   <= cmp_cnt;
        end
      end else begin
        mismatch <= '0;
      end
    end
  end

endmodule
